// File: rtl/seg_chain_fsm.sv
// Multi-channel segmented chain FSM: each channel walks IDLE -> STAGE1..DEPTH on i,
// and a mid-chain drop of i routes it through a timed DRAIN into a sticky TRAP.
module seg_chain_fsm #(
  parameter int NCH          = 4,
  parameter int DEPTH        = 2,
  parameter int DRAIN_CYCLES = 1,
  parameter int WRAP_MODE    = 1,
  parameter int CNT_W        = 8,
  localparam int SW          = $clog2(DEPTH + 3)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NCH-1:0]      en,
  input  logic [NCH-1:0]      i,
  input  logic [NCH-1:0]      clear_trap,
  output logic [NCH*SW-1:0]   state,
  output logic [NCH-1:0]      o,
  output logic [NCH-1:0]      trap,
  output logic                any_trap,
  output logic [CNT_W-1:0]    trap_count,
  output logic [NCH-1:0]      illegal
);

  localparam int DW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int PW   = $clog2(NCH + 1);
  localparam int SUMW = CNT_W + PW;

  localparam logic [SW-1:0]    S_IDLE     = '0;
  localparam logic [SW-1:0]    S_FIRST    = SW'(1);
  localparam logic [SW-1:0]    S_LAST     = SW'(DEPTH);
  localparam logic [SW-1:0]    S_DRAIN    = SW'(DEPTH + 1);
  localparam logic [SW-1:0]    S_TRAP     = SW'(DEPTH + 2);
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [NCH-1:0] enter_trap;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [SW-1:0] state_reg;
      logic [DW-1:0] drain_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          state_reg <= S_IDLE;
          drain_reg <= '0;
        end else if (en[gi]) begin
          if (state_reg == S_IDLE) begin
            if (i[gi]) state_reg <= S_FIRST;
          end else if (state_reg < S_LAST) begin
            if (i[gi]) begin
              state_reg <= state_reg + SW'(1);
            end else begin
              state_reg <= S_DRAIN;
              drain_reg <= DRAIN_LOAD;
            end
          end else if (state_reg == S_LAST) begin
            state_reg <= (WRAP_MODE != 0) ? S_FIRST : S_IDLE;
          end else if (state_reg == S_DRAIN) begin
            if (drain_reg == '0) state_reg <= S_TRAP;
            else                 drain_reg <= drain_reg - DW'(1);
          end else if (state_reg == S_TRAP) begin
            if (clear_trap[gi]) state_reg <= S_IDLE;
          end else begin
            // unreachable encodings fall back to a clean IDLE
            state_reg <= S_IDLE;
            drain_reg <= '0;
          end
        end
      end

      assign state[gi*SW +: SW] = state_reg;
      assign o[gi]              = (state_reg == S_IDLE);
      assign trap[gi]           = (state_reg == S_TRAP);
      assign illegal[gi]        = (state_reg > S_TRAP);
      assign enter_trap[gi]     = en[gi] && (state_reg == S_DRAIN) && (drain_reg == '0);
    end
  endgenerate

  assign any_trap = |trap;

  logic [PW-1:0]    enter_num;
  logic [SUMW-1:0]  count_sum;
  logic [CNT_W-1:0] trap_count_reg;
  logic [CNT_W-1:0] trap_count_next;

  // sum is one channel-count wider than the counter so the clamp sees overflow
  always_comb begin
    enter_num = '0;
    for (int k = 0; k < NCH; k++) begin
      enter_num = enter_num + PW'(enter_trap[k]);
    end
    count_sum       = SUMW'(trap_count_reg) + SUMW'(enter_num);
    trap_count_next = (count_sum > SUMW'(CNT_MAX)) ? CNT_MAX : count_sum[CNT_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) trap_count_reg <= '0;
    else       trap_count_reg <= trap_count_next;
  end

  assign trap_count = trap_count_reg;

endmodule

// File: tb/tb_seg_chain_fsm.sv
// Bench for seg_chain_fsm: five parameter variants share one stimulus stream and
// are compared every cycle against a per-channel behavioural model.
module tb_seg_chain_fsm;
  localparam int NI  = 5;
  localparam int NCH = 4;

  logic clock = 1'b0;
  logic reset;
  logic [NCH-1:0] en, i, clear_trap;

  logic [11:0] state0, state1, state2, state3;
  logic [7:0]  state4;
  logic [NCH-1:0] o_w    [NI];
  logic [NCH-1:0] trap_w [NI];
  logic [NCH-1:0] ill_w  [NI];
  logic [NI-1:0]  any_w;
  logic [7:0] tc0, tc1, tc2;
  logic [1:0] tc3;
  logic [3:0] tc4;

  int m_depth [NI] = '{2, 2, 3, 3, 1};
  int m_dc    [NI] = '{1, 3, 1, 2, 1};
  int m_wrap  [NI] = '{1, 1, 0, 1, 0};
  int m_cmax  [NI] = '{255, 255, 255, 3, 15};
  int m_sw    [NI] = '{3, 3, 3, 3, 2};

  int m_st   [NI][NCH];
  int m_left [NI][NCH];
  int m_cnt  [NI];

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  always #5 clock = ~clock;

  seg_chain_fsm #(.NCH(4), .DEPTH(2), .DRAIN_CYCLES(1), .WRAP_MODE(1), .CNT_W(8)) u0 (
    .clock(clock), .reset(reset), .en(en), .i(i), .clear_trap(clear_trap),
    .state(state0), .o(o_w[0]), .trap(trap_w[0]), .any_trap(any_w[0]),
    .trap_count(tc0), .illegal(ill_w[0]));
  seg_chain_fsm #(.NCH(4), .DEPTH(2), .DRAIN_CYCLES(3), .WRAP_MODE(1), .CNT_W(8)) u1 (
    .clock(clock), .reset(reset), .en(en), .i(i), .clear_trap(clear_trap),
    .state(state1), .o(o_w[1]), .trap(trap_w[1]), .any_trap(any_w[1]),
    .trap_count(tc1), .illegal(ill_w[1]));
  seg_chain_fsm #(.NCH(4), .DEPTH(3), .DRAIN_CYCLES(1), .WRAP_MODE(0), .CNT_W(8)) u2 (
    .clock(clock), .reset(reset), .en(en), .i(i), .clear_trap(clear_trap),
    .state(state2), .o(o_w[2]), .trap(trap_w[2]), .any_trap(any_w[2]),
    .trap_count(tc2), .illegal(ill_w[2]));
  seg_chain_fsm #(.NCH(4), .DEPTH(3), .DRAIN_CYCLES(2), .WRAP_MODE(1), .CNT_W(2)) u3 (
    .clock(clock), .reset(reset), .en(en), .i(i), .clear_trap(clear_trap),
    .state(state3), .o(o_w[3]), .trap(trap_w[3]), .any_trap(any_w[3]),
    .trap_count(tc3), .illegal(ill_w[3]));
  seg_chain_fsm #(.NCH(4), .DEPTH(1), .DRAIN_CYCLES(1), .WRAP_MODE(0), .CNT_W(4)) u4 (
    .clock(clock), .reset(reset), .en(en), .i(i), .clear_trap(clear_trap),
    .state(state4), .o(o_w[4]), .trap(trap_w[4]), .any_trap(any_w[4]),
    .trap_count(tc4), .illegal(ill_w[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  function automatic logic [31:0] get_state(input int n);
    case (n)
      0:       return 32'(state0);
      1:       return 32'(state1);
      2:       return 32'(state2);
      3:       return 32'(state3);
      default: return 32'(state4);
    endcase
  endfunction

  function automatic logic [31:0] get_tc(input int n);
    case (n)
      0:       return 32'(tc0);
      1:       return 32'(tc1);
      2:       return 32'(tc2);
      3:       return 32'(tc3);
      default: return 32'(tc4);
    endcase
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NI; n++) begin
      m_cnt[n] = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        m_st[n][ch]   = 0;
        m_left[n][ch] = 0;
      end
    end
  endtask

  // Drain is tracked as "enabled cycles still to spend", reaching TRAP when it hits zero.
  task automatic model_step(input logic [NCH-1:0] e, input logic [NCH-1:0] ii,
                            input logic [NCH-1:0] c);
    for (int n = 0; n < NI; n++) begin
      int d;
      int entered;
      d = m_depth[n];
      entered = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        int s;
        s = m_st[n][ch];
        if (e[ch]) begin
          if (s == 0) begin
            m_st[n][ch] = ii[ch] ? 1 : 0;
          end else if (s < d) begin
            if (ii[ch]) m_st[n][ch] = s + 1;
            else begin
              m_st[n][ch]   = d + 1;
              m_left[n][ch] = m_dc[n];
            end
          end else if (s == d) begin
            m_st[n][ch] = (m_wrap[n] != 0) ? 1 : 0;
          end else if (s == d + 1) begin
            m_left[n][ch] = m_left[n][ch] - 1;
            if (m_left[n][ch] == 0) begin
              m_st[n][ch] = d + 2;
              entered++;
            end
          end else if (c[ch]) begin
            m_st[n][ch] = 0;
          end
        end
      end
      m_cnt[n] = (m_cnt[n] + entered > m_cmax[n]) ? m_cmax[n] : m_cnt[n] + entered;
    end
  endtask

  task automatic compare_all();
    for (int n = 0; n < NI; n++) begin
      logic [31:0]    es;
      logic [NCH-1:0] eo, et;
      es = '0;
      eo = '0;
      et = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        es = es | (32'(m_st[n][ch]) << (ch * m_sw[n]));
        eo[ch] = (m_st[n][ch] == 0);
        et[ch] = (m_st[n][ch] == m_depth[n] + 2);
      end
      check($sformatf("u%0d_state", n),   get_state(n),      es);
      check($sformatf("u%0d_o", n),       32'(o_w[n]),       32'(eo));
      check($sformatf("u%0d_trap", n),    32'(trap_w[n]),    32'(et));
      check($sformatf("u%0d_any", n),     32'(any_w[n]),     32'(|et));
      check($sformatf("u%0d_count", n),   get_tc(n),         32'(m_cnt[n]));
      check($sformatf("u%0d_illegal", n), 32'(ill_w[n]),     32'(0));
    end
  endtask

  task automatic step(input logic r, input logic [NCH-1:0] e, input logic [NCH-1:0] ii,
                      input logic [NCH-1:0] c);
    reset      = r;
    en         = e;
    i          = ii;
    clear_trap = c;
    @(posedge clock);
    if (r) model_reset();
    else   model_step(e, ii, c);
    #1;
    n_cyc++;
    $display("cyc %0d rst=%0b en=%b i=%b clr=%b st0=%h st1=%h st2=%h st3=%h st4=%h tc0=%0d tc3=%0d",
             n_cyc, r, e, ii, c, state0, state1, state2, state3, state4, tc0, tc3);
    compare_all();
  endtask

  initial begin
    int e2 [4];
    int e3 [4];
    logic [NCH-1:0] re, ri, rc;
    logic rr;
    e2 = '{1, 2, 3, 0};
    e3 = '{1, 2, 3, 1};

    step(1'b1, 4'h0, 4'h0, 4'h0);
    step(1'b1, 4'h0, 4'h0, 4'h0);
    check("reset_state", 32'(state0), 32'h0);
    check("reset_o", 32'(o_w[0]), 32'hF);
    check("reset_count", 32'(tc0), 32'h0);

    // reset in the middle of a walk
    step(1'b0, 4'hF, 4'h1, 4'h0);
    step(1'b0, 4'hF, 4'h1, 4'h0);
    check("midwalk_stage2", 32'(state0[2:0]), 32'd2);
    step(1'b1, 4'hF, 4'hF, 4'hF);
    check("midreset_state", 32'(state0), 32'h0);
    check("midreset_o", 32'(o_w[0]), 32'hF);
    check("midreset_count", 32'(tc0), 32'h0);

    // walk with wrap, then drop mid-chain into TRAP
    step(1'b0, 4'hF, 4'h1, 4'h0);
    check("walk_1", 32'(state0[2:0]), 32'd1);
    step(1'b0, 4'hF, 4'h1, 4'h0);
    check("walk_2", 32'(state0[2:0]), 32'd2);
    step(1'b0, 4'hF, 4'h0, 4'h0);
    check("walk_wrap", 32'(state0[2:0]), 32'd1);
    step(1'b1, 4'h0, 4'h0, 4'h0);
    step(1'b0, 4'hF, 4'h1, 4'h0);
    step(1'b0, 4'hF, 4'h0, 4'h0);
    check("drop_drain", 32'(state0[2:0]), 32'd3);
    step(1'b0, 4'hF, 4'h0, 4'h0);
    check("drop_trap", 32'(state0[2:0]), 32'd4);
    check("drop_trapflag", 32'(trap_w[0][0]), 32'd1);

    // three-cycle drain stretched by an en=0 gap
    step(1'b1, 4'h0, 4'h0, 4'h0);
    step(1'b0, 4'hF, 4'h1, 4'h0);
    step(1'b0, 4'hF, 4'h0, 4'h0);
    check("drain3_a", 32'(state1[2:0]), 32'd3);
    step(1'b0, 4'hF, 4'h0, 4'h0);
    check("drain3_b", 32'(state1[2:0]), 32'd3);
    step(1'b0, 4'h0, 4'h0, 4'h0);
    check("drain3_hold", 32'(state1[2:0]), 32'd3);
    step(1'b0, 4'hF, 4'h0, 4'h0);
    check("drain3_c", 32'(state1[2:0]), 32'd3);
    step(1'b0, 4'hF, 4'h0, 4'h0);
    check("drain3_trap", 32'(state1[2:0]), 32'd4);

    // clear_trap needs en and only acts in TRAP
    step(1'b1, 4'h0, 4'h0, 4'h0);
    step(1'b0, 4'hF, 4'h2, 4'h0);
    step(1'b0, 4'hF, 4'h0, 4'h0);
    step(1'b0, 4'hF, 4'h0, 4'h0);
    check("clr_trap_in", 32'(state0[5:3]), 32'd4);
    step(1'b0, 4'h0, 4'h0, 4'h2);
    check("clr_no_en", 32'(state0[5:3]), 32'd4);
    step(1'b0, 4'hF, 4'h0, 4'h2);
    check("clr_en", 32'(state0[5:3]), 32'd0);
    step(1'b0, 4'hF, 4'h2, 4'h0);
    step(1'b0, 4'hF, 4'h2, 4'h2);
    check("clr_in_stage", 32'(state0[5:3]), 32'd2);

    // wrap modes at DEPTH=3
    step(1'b1, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'hF, 4'h1, 4'h0);
      check($sformatf("nowrap_%0d", k), 32'(state2[2:0]), 32'(e2[k]));
      check($sformatf("wrap_%0d", k), 32'(state3[2:0]), 32'(e3[k]));
    end

    // all channels trap together twice; narrow counter saturates
    step(1'b1, 4'h0, 4'h0, 4'h0);
    for (int r = 0; r < 2; r++) begin
      step(1'b0, 4'hF, 4'hF, 4'h0);
      for (int k = 0; k < 4; k++) step(1'b0, 4'hF, 4'h0, 4'h0);
      step(1'b0, 4'hF, 4'h0, 4'hF);
      check($sformatf("sat_tc3_r%0d", r), 32'(tc3), 32'd3);
      check($sformatf("sat_tc0_r%0d", r), 32'(tc0), 32'(4 * (r + 1)));
    end

    // random stress against the model
    for (int k = 0; k < 400; k++) begin
      rr = ($urandom_range(0, 49) == 0);
      re = NCH'(~($urandom & $urandom & $urandom));
      ri = NCH'(~($urandom & $urandom));
      rc = NCH'($urandom & $urandom);
      step(rr, re, ri, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
